// File: rtl/phy_rx_lane.sv
// Single-lane serial receive deserializer.
// Acquires byte alignment from COM symbols, then strobes out recovered bytes.
module phy_rx_lane #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_nxt;
  logic       is_com;
  logic       boundary;
  logic       realign;
  logic       strobe_nxt;

  assign is_com   = (sr == COM);
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    case (state)
      SEARCH: begin
        if (is_com) begin
          com_cnt_nxt = 4'd1;
          state_nxt   = (LOCK_N <= 4'd1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_nxt = com_cnt + 4'd1;
            if (com_cnt_nxt >= LOCK_N) begin
              com_cnt_nxt = LOCK_N;
              state_nxt   = ACTIVE;
            end
          end else begin
            com_cnt_nxt = 4'd0;
            state_nxt   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        state_nxt = ACTIVE;
      end
      default: begin
        state_nxt   = SEARCH;
        com_cnt_nxt = 4'd0;
      end
    endcase
  end

  // A match while searching defines the boundary; restart the byte count.
  always_comb begin
    realign    = (state == SEARCH) && is_com;
    strobe_nxt = (state == ACTIVE) && boundary;
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr          <= 8'd0;
      bit_cnt     <= 3'd0;
      com_cnt     <= 4'd0;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr          <= {sr[6:0], serial_in};
      bit_cnt     <= realign ? 3'd0 : bit_cnt + 3'd1;
      com_cnt     <= com_cnt_nxt;
      byte_strobe <= strobe_nxt;
      active      <= (state_nxt == ACTIVE);
      if (strobe_nxt) begin
        data_out  <= sr;
        valid_out <= !is_com;
      end
    end
  end

endmodule

// File: doc/phy_rx_lane.md
# phy_rx_lane

Single-lane receive deserializer for the PHY link. It consumes one serial line running at clk_8f, MSB-first, one byte every 8 cycles. It acquires byte alignment from the COM symbol the transmit side emits whenever it has no valid data. Once aligned, it recovers each byte with its valid flag and a one-cycle strobe. Two instances, one per serial line, feed the receive-side un-striping and demux logic.

## Interface
- COM, 8'hBC: comma/idle symbol; the transmitter sends it when valid is low.
- LOCK_COUNT, 4: number of consecutive aligned COM bytes required to declare lock (range 1..15).
- clk_8f  input  1  bit clock; one serial bit sampled per rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data, MSB first.
- data_out  output  8  recovered byte.
- valid_out  output  1  high when the last strobed byte was data (not COM).
- byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  high while lane is locked (state ACTIVE).

## Operation
- Shift register sr[7:0]: sr <= {sr[6:0], serial_in} every cycle, including in SEARCH. Reset clears sr to 0.
- Bit counter bit_cnt[2:0]: marks a byte boundary when the counter wraps. The boundary is the cycle in which sr holds a complete byte.
- COM counter com_cnt[3:0].
- States:
  - SEARCH (reset state): compare sr to COM every cycle, at any alignment. On match, that cycle becomes a boundary: bit_cnt restarts so the next boundary is 8 cycles later, com_cnt <= 1, go to LOCKING. If LOCK_COUNT == 1, go directly to ACTIVE.
  - LOCKING: evaluate only at boundaries.
    - sr == COM: com_cnt++. When com_cnt reaches LOCK_COUNT, go to ACTIVE.
    - sr != COM: com_cnt <= 0, go to SEARCH. Comparison resumes from the next cycle.
    - No byte_strobe is issued in LOCKING.
  - ACTIVE: at every boundary, data_out <= sr, valid_out <= (sr != COM), byte_strobe <= 1 for exactly one cycle.
    - COM bytes are strobed with valid_out = 0 and data_out = 8'hBC.
    - The lane stays ACTIVE until reset; there is no in-band loss-of-lock detection.
- Between strobes, data_out and valid_out hold their last values.
- Reset values, applied at the first clk_8f edge with reset high:
  - data_out = 0, valid_out = 0, byte_strobe = 0, active = 0.
  - State SEARCH, sr = 0, bit_cnt = 0, com_cnt = 0.
- Reset asserted mid-operation (any state): all of the above on the next edge. Any partially received byte is discarded. Search restarts from the first sample after reset deasserts.

## Timing
- Define edge E as the edge that samples the last (LSB) bit of a byte into sr. Cycle E is then a boundary.
- Data latency in ACTIVE: data_out, valid_out and byte_strobe update at edge E+1. byte_strobe is high for the cycle after E+1 only.
- Strobe cadence in ACTIVE: exactly one byte_strobe every 8 cycles, with no gaps and no doubles.
- Lock latency: the LOCK_COUNT-th consecutive COM completes at edge E. active rises at E+1. The first data byte after that COM is strobed 8 cycles later.
- COM straddling alignment in LOCKING is not special-cased. A COM at the wrong alignment is a mismatch and sends the block to SEARCH.
- Simultaneous events:
  - reset overrides every state transition and strobe.
  - In SEARCH, a COM match on the same cycle reset deasserts is not possible, because sr is 0 on that cycle.
- Width rules: com_cnt saturates at LOCK_COUNT; bit_cnt wraps modulo 8.

## Test plan
- Reset: hold reset 3 cycles with random serial_in -> data_out = 0, valid_out = 0, byte_strobe = 0, active = 0 throughout and on the first cycle after release.
- Clean lock: after reset, send BC,BC,BC,BC,5A,3C MSB-first -> active rises 1 cycle after the 4th BC's LSB. Then byte_strobe pulses with data_out = 5A/valid_out = 1, and 8 cycles later data_out = 3C/valid_out = 1.
- Misaligned start: 3 random bits, then BC×4, then A5 -> lock is achieved at the shifted alignment. data_out = A5 and valid_out = 1, exactly 8 cycles after active rises.
- Interrupted lock: BC,BC,11,BC,BC,BC,BC,77 -> active stays 0 through the 11 byte. Lock occurs on the second BC run, then data_out = 77 and valid_out = 1.
- Idle in ACTIVE: after lock, send 22,BC,BC,33 -> four strobes at 8-cycle spacing with (22,1), (BC,0), (BC,0), (33,1).
- Reset mid-byte: assert reset 4 bits into a data byte while ACTIVE -> all outputs 0 on the next edge. After release, BC×4 re-locks with the same latency as the clean-lock case.
